// File: rtl/bsg_manycore_link_sdr_reset_sequencer_if.sv
// Bring-up control bundle between the reset sequencer (master) and the SDR link pair it drives.
interface bsg_manycore_link_sdr_reset_sequencer_if;
  logic       start;
  logic [3:0] cfg_disable;
  logic       uplink_reset;
  logic       downlink_reset;
  logic       downstream_reset;
  logic       token_reset;
  logic [3:0] link_disable;
  logic       busy;
  logic       done;

  modport master (
    input  start, cfg_disable,
    output uplink_reset, downlink_reset, downstream_reset, token_reset, link_disable, busy, done
  );

  modport slave (
    output start, cfg_disable,
    input  uplink_reset, downlink_reset, downstream_reset, token_reset, link_disable, busy, done
  );
endinterface

// File: rtl/bsg_manycore_link_sdr_reset_sequencer.sv
// Staged reset release for a manycore SDR link pair: hold all resets, pulse the token reset,
// then release uplink, downlink and downstream one step at a time. All outputs are flops.
module bsg_manycore_link_sdr_reset_sequencer #(
  parameter int unsigned assert_cycles_p = 16,
  parameter int unsigned token_cycles_p  = 4,
  parameter int unsigned gap_cycles_p    = 8
) (
  input  logic clk_i,
  input  logic reset_i,
  bsg_manycore_link_sdr_reset_sequencer_if.master link_io
);

  localparam int unsigned cnt_width_lp = $clog2(1024) + 1;
  localparam logic [cnt_width_lp-1:0] assert_load_lp = cnt_width_lp'(assert_cycles_p - 1);
  localparam logic [cnt_width_lp-1:0] token_load_lp  = cnt_width_lp'(token_cycles_p - 1);
  localparam logic [cnt_width_lp-1:0] gap_load_lp    = cnt_width_lp'(gap_cycles_p - 1);

  typedef enum logic [2:0] {
    StIdle, StAssert, StToken, StTokenGap, StUpRel, StDownRel, StDone
  } state_e;

  state_e                  state_q, state_d;
  logic [cnt_width_lp-1:0] cnt_q, cnt_d;
  // {uplink, downlink, downstream, token, busy, done}
  logic [5:0]              out_q, out_d;
  logic [3:0]              dis_q, dis_d;
  logic                    expired;

  assign expired = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dis_d   = dis_q;
    case (state_q)
      StIdle, StDone: begin
        if (link_io.start) begin
          state_d = StAssert;
          cnt_d   = assert_load_lp;
          dis_d   = link_io.cfg_disable;
        end
      end
      StAssert: begin
        if (expired) begin
          state_d = StToken;
          cnt_d   = token_load_lp;
        end else cnt_d = cnt_q - 1'b1;
      end
      StToken: begin
        if (expired) begin
          state_d = StTokenGap;
          cnt_d   = gap_load_lp;
        end else cnt_d = cnt_q - 1'b1;
      end
      StTokenGap: begin
        if (expired) begin
          state_d = StUpRel;
          cnt_d   = gap_load_lp;
        end else cnt_d = cnt_q - 1'b1;
      end
      StUpRel: begin
        if (expired) begin
          state_d = StDownRel;
          cnt_d   = gap_load_lp;
        end else cnt_d = cnt_q - 1'b1;
      end
      StDownRel: begin
        if (expired) begin
          state_d = StDone;
          cnt_d   = '0;
        end else cnt_d = cnt_q - 1'b1;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they leave the flop already settled.
  always_comb begin
    out_d = 6'b111000;
    case (state_d)
      StIdle:     out_d = 6'b111000;
      StAssert:   out_d = 6'b111010;
      StToken:    out_d = 6'b111110;
      StTokenGap: out_d = 6'b111010;
      StUpRel:    out_d = 6'b011010;
      StDownRel:  out_d = 6'b001010;
      StDone:     out_d = 6'b000001;
      default:    out_d = 6'b111000;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      out_q   <= 6'b111000;
      dis_q   <= 4'b1111;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      dis_q   <= dis_d;
    end
  end

  assign link_io.uplink_reset     = out_q[5];
  assign link_io.downlink_reset   = out_q[4];
  assign link_io.downstream_reset = out_q[3];
  assign link_io.token_reset      = out_q[2];
  assign link_io.busy             = out_q[1];
  assign link_io.done             = out_q[0];
  assign link_io.link_disable     = dis_q;

endmodule

// File: tb/tb_bsg_manycore_link_sdr_reset_sequencer.sv
// Scoreboard bench: a nominal-count sequencer (4/2/3) and a minimum-count one (1/1/1).
module tb_bsg_manycore_link_sdr_reset_sequencer;

  typedef struct packed {
    logic [5:0] outs;
    logic [3:0] dis;
  } exp_t;

  localparam logic [5:0] OutIdle   = 6'b111000;
  localparam logic [5:0] OutAssert = 6'b111010;
  localparam logic [5:0] OutToken  = 6'b111110;
  localparam logic [5:0] OutTgap   = 6'b111010;
  localparam logic [5:0] OutUp     = 6'b011010;
  localparam logic [5:0] OutDown   = 6'b001010;
  localparam logic [5:0] OutDone   = 6'b000001;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t q_n[$];
  exp_t q_m[$];
  logic [5:0] prev_m = OutIdle;

  always #5 clk = ~clk;

  bsg_manycore_link_sdr_reset_sequencer_if lnk_n ();
  bsg_manycore_link_sdr_reset_sequencer_if lnk_m ();

  bsg_manycore_link_sdr_reset_sequencer #(
    .assert_cycles_p(4),
    .token_cycles_p (2),
    .gap_cycles_p   (3)
  ) dut_n (
    .clk_i  (clk),
    .reset_i(reset),
    .link_io(lnk_n)
  );

  bsg_manycore_link_sdr_reset_sequencer #(
    .assert_cycles_p(1),
    .token_cycles_p (1),
    .gap_cycles_p   (1)
  ) dut_m (
    .clk_i  (clk),
    .reset_i(reset),
    .link_io(lnk_m)
  );

  logic [5:0] outs_n, outs_m;
  assign outs_n = {lnk_n.uplink_reset, lnk_n.downlink_reset, lnk_n.downstream_reset,
                   lnk_n.token_reset, lnk_n.busy, lnk_n.done};
  assign outs_m = {lnk_m.uplink_reset, lnk_m.downlink_reset, lnk_m.downstream_reset,
                   lnk_m.token_reset, lnk_m.busy, lnk_m.done};

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void push_exp(input int sel, input logic [5:0] o, input logic [3:0] d,
                                   input int n);
    exp_t e;
    e.outs = o;
    e.dis  = d;
    for (int i = 0; i < n; i++) begin
      if (sel == 0) q_n.push_back(e);
      else q_m.push_back(e);
    end
  endfunction

  function automatic void push_run(input int sel, input int a, input int tk, input int g,
                                   input logic [3:0] d, input int tail);
    push_exp(sel, OutAssert, d, a);
    push_exp(sel, OutToken,  d, tk);
    push_exp(sel, OutTgap,   d, g);
    push_exp(sel, OutUp,     d, g);
    push_exp(sel, OutDown,   d, g);
    push_exp(sel, OutDone,   d, tail);
  endfunction

  // Returns 1ns after the edge that samples start high; expectations cover t+1 onward.
  task automatic start_run(input int sel, input logic [3:0] d);
    @(posedge clk);
    #2;
    if (sel == 0) begin
      lnk_n.start       = 1'b1;
      lnk_n.cfg_disable = d;
    end else begin
      lnk_m.start       = 1'b1;
      lnk_m.cfg_disable = d;
    end
    @(posedge clk);
    #1;
    if (sel == 0) begin
      lnk_n.start = 1'b0;
      push_run(0, 4, 2, 3, d, 2);
    end else begin
      lnk_m.start = 1'b0;
      push_run(1, 1, 1, 1, d, 2);
    end
  endtask

  always @(negedge clk) begin
    if (q_n.size() != 0) begin
      exp_t e;
      e = q_n.pop_front();
      check_val("nom_seq", {outs_n, lnk_n.link_disable}, e);
      check_val("nom_excl", lnk_n.busy & lnk_n.done, 0);
    end
  end

  always @(negedge clk) begin
    if (q_m.size() != 0) begin
      exp_t e;
      e = q_m.pop_front();
      check_val("min_seq", {outs_m, lnk_m.link_disable}, e);
      check_val("min_excl", lnk_m.busy & lnk_m.done, 0);
      if (!(prev_m[0] && outs_m[1]))
        check_val("min_onechg", $countones(outs_m[5:2] ^ prev_m[5:2]) <= 1, 1);
      prev_m <= outs_m;
    end
  end

  initial begin
    reset             = 1'b1;
    lnk_n.start       = 1'b0;
    lnk_n.cfg_disable = 4'b0000;
    lnk_m.start       = 1'b0;
    lnk_m.cfg_disable = 4'b0000;
    #1;
    check_val("rst_outs_n", outs_n, OutIdle);
    check_val("rst_dis_n", lnk_n.link_disable, 4'b1111);
    check_val("rst_outs_m", outs_m, OutIdle);
    check_val("rst_dis_m", lnk_m.link_disable, 4'b1111);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    push_exp(0, OutIdle, 4'b1111, 3);
    repeat (3) @(posedge clk);

    // Nominal run; cfg change mid-run must not reach link_disable.
    start_run(0, 4'b0101);
    #3;
    lnk_n.cfg_disable = 4'b1010;
    repeat (17) @(posedge clk);

    // Re-init from DONE with start pulses during TOKEN and DOWN_REL.
    start_run(0, 4'b0011);
    repeat (4) @(posedge clk);
    #2;
    lnk_n.start = 1'b1;
    @(posedge clk);
    #1;
    lnk_n.start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    lnk_n.start = 1'b1;
    @(posedge clk);
    #1;
    lnk_n.start = 1'b0;
    repeat (4) @(posedge clk);

    // Async reset mid-clock during UP_REL.
    start_run(0, 4'b1100);
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b1;
    q_n.delete();
    #1;
    check_val("async_outs", outs_n, OutIdle);
    check_val("async_dis", lnk_n.link_disable, 4'b1111);
    push_exp(0, OutIdle, 4'b1111, 5);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (4) @(posedge clk);

    start_run(0, 4'b0110);
    repeat (17) @(posedge clk);

    // Minimum counts, including a DONE -> ASSERT re-init.
    start_run(1, 4'b1001);
    repeat (8) @(posedge clk);
    start_run(1, 4'b0010);
    repeat (8) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
